// File: rtl/softmax_norm.sv
// softmax_norm: normalisation stage of the approximate softmax.
// Buffers N exp words, sums them, then emits exp_i/sum as Q0.16.
module softmax_norm #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int SUM_W = 32 + $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [20:0]      in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_prob,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);
    typedef enum logic [1:0] {ACCUM, DIV, OUT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
    localparam logic [4:0] ITER_END = 5'd17;

    state_t state, state_next;

    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [SUM_W-1:0] sum;
    logic [31:0]      mem [N];
    logic [SUM_W:0]   rem;
    logic [16:0]      dvd;
    logic [16:0]      quo;
    logic [4:0]       iter;
    logic [15:0]      prob;

    logic [4:0]     pos;
    logic [31:0]    fix;
    logic           take;
    logic [SUM_W:0] sum_ext;
    logic [SUM_W:0] rem_sh;
    logic [SUM_W:0] rem_sub;
    logic           ge;
    logic [16:0]    quo_next;
    logic [15:0]    prob_next;

    always_comb begin
        pos = (in_exp[20:16] > 5'd16) ? 5'd16 : in_exp[20:16];
        fix = {16'b0, in_exp[15:0]} << pos;
    end

    assign take     = in_valid && in_ready;
    assign sum_ext  = {1'b0, sum};
    assign rem_sh   = {rem[SUM_W-1:0], dvd[16]};
    assign ge       = rem_sh >= sum_ext;
    assign rem_sub  = rem_sh - sum_ext;
    assign quo_next = {quo[15:0], ge};

    // A zero sum makes every trial subtraction succeed; force q=0 instead
    always_comb begin
        prob_next = quo_next[15:0];
        if (sum == '0)
            prob_next = 16'h0000;
        else if (quo_next[16])
            prob_next = 16'hFFFF;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (take && cnt == LAST) state_next = DIV;
            DIV:   if (iter == ITER_END) state_next = OUT;
            OUT:   if (out_ready) state_next = (idx == LAST) ? ACCUM : DIV;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (take)
            mem[cnt] <= fix;
    end

    // iter 0 loads the divider, iters 1..17 each retire one quotient bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            idx  <= '0;
            sum  <= '0;
            iter <= '0;
            rem  <= '0;
            dvd  <= '0;
            quo  <= '0;
            prob <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (take) begin
                        sum  <= sum + SUM_W'(fix);
                        cnt  <= (cnt == LAST) ? '0 : cnt + IDX_W'(1);
                        iter <= '0;
                    end
                end
                DIV: begin
                    iter <= iter + 5'd1;
                    if (iter == 5'd0) begin
                        rem <= {{(SUM_W - 30){1'b0}}, mem[idx][31:1]};
                        dvd <= {mem[idx][0], 16'b0};
                        quo <= '0;
                    end else begin
                        rem <= ge ? rem_sub : rem_sh;
                        dvd <= {dvd[15:0], 1'b0};
                        quo <= quo_next;
                        if (iter == ITER_END)
                            prob <= prob_next;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        iter <= '0;
                        if (idx == LAST) begin
                            idx <= '0;
                            sum <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);
    assign out_prob  = prob;
    assign out_idx   = idx;
    assign out_last  = (state == OUT) && (idx == LAST);
endmodule

// File: tb/tb_softmax_norm.sv
// tb_softmax_norm: directed and random vectors against an arithmetic
// model of exp_i/sum with saturation and zero-sum handling.
module tb_softmax_norm;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prob;
    logic [1:0]  out_idx;
    logic        out_last;

    int compared = 0;
    int mismatched = 0;

    typedef logic [20:0] vec_t [N];

    softmax_norm #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_exp(in_exp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_prob(out_prob),
        .out_idx(out_idx),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Real value of a word in units of 2^-16
    function automatic longint word_val(input logic [20:0] w);
        int p;
        p = int'(w[20:16]);
        if (p > 16) p = 16;
        return longint'(w[15:0]) << p;
    endfunction

    function automatic logic [15:0] model_prob(input vec_t v, input int k);
        longint s;
        longint q;
        s = 0;
        for (int j = 0; j < N; j++) s += word_val(v[j]);
        if (s == 0) return 16'h0000;
        q = (word_val(v[k]) << 16) / s;
        if (q >= 65536) return 16'hFFFF;
        return q[15:0];
    endfunction

    task automatic run_vector(input vec_t v, input int stall_idx,
                              input int rst_idx);
        int waited;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_exp = v[k];
            check("in_ready", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int e = 0; e < N; e++) begin
            if (e == rst_idx) begin
                repeat (5) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_in_ready", 32'(in_ready), 32'd1);
                check("rst_out_idx", 32'(out_idx), 32'd0);
                check("rst_out_prob", 32'(out_prob), 32'd0);
                check("rst_out_last", 32'(out_last), 32'd0);
                return;
            end
            waited = 0;
            while (!out_valid && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            check("latency", 32'(waited), 32'd18);
            check("prob", 32'(out_prob), 32'(model_prob(v, e)));
            check("idx", 32'(out_idx), 32'(e));
            check("last", 32'(out_last), 32'(e == N - 1));
            if (e == stall_idx) begin
                out_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    in_valid = j[0];
                    in_exp = 21'h18000;
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_prob", 32'(out_prob), 32'(model_prob(v, e)));
                    check("stall_idx", 32'(out_idx), 32'(e));
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                end
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic back_to_back(input vec_t a, input vec_t b);
        logic [20:0] words [2*N];
        int sent;
        int done;
        int budget;
        bit gated;
        logic [15:0] ep;
        for (int k = 0; k < N; k++) begin
            words[k] = a[k];
            words[N+k] = b[k];
        end
        sent = 0;
        done = 0;
        budget = 0;
        gated = 1'b0;
        out_ready = 1'b1;
        while (done < 2 * N && budget < 300) begin
            @(negedge clk);
            budget++;
            if (out_valid) begin
                ep = (done < N) ? model_prob(a, done) : model_prob(b, done - N);
                check("b2b_prob", 32'(out_prob), 32'(ep));
                check("b2b_idx", 32'(out_idx), 32'(done % N));
                check("b2b_last", 32'(out_last), 32'((done % N) == N - 1));
                done++;
            end
            if (sent == N && in_ready && !gated) begin
                check("b2b_gate", 32'(done), 32'(N));
                gated = 1'b1;
            end
            if (sent < 2 * N) begin
                in_valid = 1'b1;
                in_exp = words[sent];
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("b2b_sent", 32'(sent), 32'(2 * N));
        check("b2b_done", 32'(done), 32'(2 * N));
    endtask

    initial begin
        vec_t v;
        vec_t w;
        rst = 1'b1;
        in_valid = 1'b0;
        in_exp = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_prob", 32'(out_prob), 32'd0);
        check("reset_out_idx", 32'(out_idx), 32'd0);
        check("reset_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;

        v = '{21'h18000, 21'h18000, 21'h18000, 21'h18000};
        run_vector(v, -1, -1);
        v = '{21'h18000, 21'h28000, 21'h18000, 21'h18000};
        run_vector(v, -1, -1);
        v = '{21'h0F8000, 21'h00000, 21'h00000, 21'h00000};
        run_vector(v, -1, -1);
        v = '{21'h00000, 21'h00000, 21'h00000, 21'h00000};
        run_vector(v, -1, -1);
        v = '{21'h18000, 21'h28000, 21'h18000, 21'h18000};
        run_vector(v, 1, -1);
        v = '{21'h18000, 21'h18000, 21'h18000, 21'h18000};
        run_vector(v, -1, 2);
        run_vector(v, -1, -1);
        v = '{21'h140001, 21'h18000, 21'h28000, 21'h00000};
        run_vector(v, -1, -1);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < N; k++) begin
                w[k][20:16] = 5'($urandom_range(0, 20));
                w[k][15:0] = 16'($urandom);
                if ($urandom_range(0, 3) == 0) w[k] = '0;
            end
            run_vector(w, -1, -1);
        end

        w = '{21'h18000, 21'h28000, 21'h18000, 21'h18000};
        back_to_back(v, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
